// File: rtl/shift_reg_pkg.sv
// Shared constants for the shift_reg4_pl universal shift register.
// Optional left-shift support is controlled by the SHIFT_REG_LEFT_EN macro.
package shift_reg_pkg;

   // Values of the shr input.
   localparam logic MODE_LOAD  = 1'b0;
   localparam logic MODE_SHIFT = 1'b1;

   // Values of the dir input. dir only exists when SHIFT_REG_LEFT_EN is defined.
   localparam logic DIR_RIGHT  = 1'b0;
   localparam logic DIR_LEFT   = 1'b1;

   localparam int   SHREG_W_DEF = 4;

endpackage : shift_reg_pkg

// File: rtl/shift_reg_cell.sv
// One bit of the shift register: a flop with async active-low clear and a
// next-state mux. The mux picks the parallel bit or a neighbour bit.
// hi_i is the bit one position toward the MSB, which is the source for a right shift.
// lo_i is the bit one position toward the LSB, which is the source for a left shift.
// lo_i and dir_i exist only when SHIFT_REG_LEFT_EN is defined.
module shift_reg_cell
   import shift_reg_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic shr_i,
`ifdef SHIFT_REG_LEFT_EN
   input  logic dir_i,
   input  logic lo_i,
`endif
   input  logic par_i,
   input  logic hi_i,
   output logic q_o
);

   logic data_q;
   logic data_d;

   // Next-state select: parallel load, or a neighbour bit when shifting.
   always_comb begin
      data_d = par_i;
      if (shr_i == MODE_SHIFT) begin
`ifdef SHIFT_REG_LEFT_EN
         data_d = (dir_i == DIR_LEFT) ? lo_i : hi_i;
`else
         data_d = hi_i;
`endif
      end
   end

   // Bit storage. The clear acts immediately, without waiting for a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= 1'b0;
      end else begin
         data_q <= data_d;
      end
   end

   assign q_o = data_q;

endmodule : shift_reg_cell

// File: rtl/shift_reg4_pl.sv
// Universal shift register with two modes: parallel load and shift-right
// with serial input. The serial input is pin[WIDTH-1] and the serial output
// is the LSB.
// Defining SHIFT_REG_LEFT_EN adds a dir port. With dir=1 the register
// shifts left, takes its serial input from pin[0], and drives sout from the MSB.
module shift_reg4_pl
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = SHREG_W_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] pin,
   input  logic             shr,
`ifdef SHIFT_REG_LEFT_EN
   input  logic             dir,
`endif
   output logic [WIDTH-1:0] out,
   output logic             sout
);

   logic [WIDTH-1:0] cell_q;
   logic [WIDTH-1:0] shr_src;
`ifdef SHIFT_REG_LEFT_EN
   logic [WIDTH-1:0] shl_src;
`endif

   // Neighbour sources for each bit. Only pin[WIDTH-1] or pin[0] enters a
   // shift, so the other pin bits cannot leak X into the register.
   assign shr_src = {pin[WIDTH-1], cell_q[WIDTH-1:1]};
`ifdef SHIFT_REG_LEFT_EN
   assign shl_src = {cell_q[WIDTH-2:0], pin[0]};
`endif

   // One cell per register bit.
   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      shift_reg_cell u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .shr_i (shr),
`ifdef SHIFT_REG_LEFT_EN
         .dir_i (dir),
         .lo_i  (shl_src[i]),
`endif
         .par_i (pin[i]),
         .hi_i  (shr_src[i]),
         .q_o   (cell_q[i])
      );
   end

   assign out = cell_q;

   // sout is taken straight from the register, with no added latency. It
   // reads 0 during reset because the cells are cleared.
`ifdef SHIFT_REG_LEFT_EN
   assign sout = (dir == DIR_LEFT) ? cell_q[WIDTH-1] : cell_q[0];
`else
   assign sout = cell_q[0];
`endif

endmodule : shift_reg4_pl

// File: tb/tb_shift_reg4_pl.sv
// Self-checking bench for shift_reg4_pl.
// The reference model keeps the register as an integer and applies load or
// shift with arithmetic. Directed steps pin literal values, and a randomised
// phase that includes mid-cycle resets follows.
module tb_shift_reg4_pl;

   localparam int W = 4;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] pin;
   logic         shr;
   logic         dir;
   logic [W-1:0] out;
   logic         sout;

   int checks = 0;
   int errors = 0;

   int unsigned model_val;

   shift_reg4_pl #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .pin   (pin),
      .shr   (shr),
`ifdef SHIFT_REG_LEFT_EN
      .dir   (dir),
`endif
      .out   (out),
      .sout  (sout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model. The register is an integer; load copies pin, and a
   // shift divides or multiplies by two and adds in the serial bit.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_val <= 0;
      end else if (shr == 1'b0) begin
         model_val <= int'(pin);
`ifdef SHIFT_REG_LEFT_EN
      end else if (dir == 1'b1) begin
         model_val <= ((model_val * 2) % (1 << W)) + (int'(pin) % 2);
`endif
      end else begin
         model_val <= (model_val / 2) + ((int'(pin) / (1 << (W-1))) % 2) * (1 << (W-1));
      end
   end

   function automatic int unsigned exp_sout(input int unsigned v, input logic d);
`ifdef SHIFT_REG_LEFT_EN
      if (d) return (v / (1 << (W-1))) % 2;
`endif
      return v % 2;
   endfunction

   // Continuous comparison on every falling edge.
   always @(negedge clk) begin
      chk("model_out", 32'(out), 32'(model_val));
      chk("model_sout", 32'(sout), 32'(exp_sout(model_val, dir)));
   end

   // Drives inputs at the falling edge, then returns 1 time unit after the next rising edge.
   task automatic step(input logic s, input logic [W-1:0] p);
      @(negedge clk);
      shr = s;
      pin = p;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [W-1:0] word;
      rst_n = 1'b0;
      pin   = '0;
      shr   = 1'b0;
      dir   = 1'b0;

      repeat (2) @(posedge clk);
      chk("reset_out", 32'(out), 32'h0);

      // Reset held low across a rising edge must block the load.
      @(negedge clk);
      shr = 1'b0; pin = 4'b1111;
      @(posedge clk); #1;
      chk("no_update_in_reset", 32'(out), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Load 1011, then assert reset in the middle of the cycle.
      step(1'b0, 4'b1011);
      chk("pre_reset_load", 32'(out), 32'hB);
      #2 rst_n = 1'b0;
      #1;
      chk("async_reset_out", 32'(out), 32'h0);
      chk("async_reset_sout", 32'(sout), 32'h0);
      @(negedge clk);
      rst_n = 1'b1; shr = 1'b0; pin = 4'b0110;
      @(posedge clk); #1;
      chk("release_load", 32'(out), 32'h6);

      // Consecutive parallel loads.
      step(1'b0, 4'b1011); chk("load_1011", 32'(out), 32'hB); chk("load_sout1", 32'(sout), 1);
      step(1'b0, 4'b0101); chk("load_0101", 32'(out), 32'h5); chk("load_sout2", 32'(sout), 1);
      step(1'b0, 4'b0000); chk("load_0000", 32'(out), 32'h0); chk("load_sout3", 32'(sout), 0);

      // Serial word 1010 entered LSB first on pin[3].
      step(1'b1, 4'b0000); chk("sin_1", 32'(out), 32'h0);
      step(1'b1, 4'b1000); chk("sin_2", 32'(out), 32'h8);
      step(1'b1, 4'b0000); chk("sin_3", 32'(out), 32'h4);
      step(1'b1, 4'b1000); chk("sin_4", 32'(out), 32'hA);

      // Keep shifting with pin[3]=1 held; pin[2:0] carry junk.
      step(1'b1, 4'b1010); chk("cont_1", 32'(out), 32'hD); chk("cont_s1", 32'(sout), 1);
      step(1'b1, 4'b1101); chk("cont_2", 32'(out), 32'hE); chk("cont_s2", 32'(sout), 0);
      step(1'b1, 4'b1011); chk("cont_3", 32'(out), 32'hF); chk("cont_s3", 32'(sout), 1);
      step(1'b1, 4'b1111); chk("cont_4", 32'(out), 32'hF); chk("cont_s4", 32'(sout), 1);

      // Load 1001, then serialise it out LSB first.
      step(1'b0, 4'b1001); chk("ser_load", 32'(sout), 1);
      word = 4'(($urandom_range(0, 7)));
      step(1'b1, word); chk("ser_s1", 32'(sout), 0);
      word = 4'(($urandom_range(0, 7)));
      step(1'b1, word); chk("ser_s2", 32'(sout), 0);
      word = 4'(($urandom_range(0, 7)));
      step(1'b1, word); chk("ser_s3", 32'(sout), 1);
      word = 4'(($urandom_range(0, 7)));
      step(1'b1, word); chk("ser_final", 32'(out), 32'h0);

`ifdef SHIFT_REG_LEFT_EN
      // Left shift from 0001 with pin[0]=1, then one right shift.
      step(1'b0, 4'b0001);
      dir = 1'b1;
      step(1'b1, 4'b0001); chk("left_1", 32'(out), 32'h3);
      step(1'b1, 4'b0001); chk("left_2", 32'(out), 32'h7);
      step(1'b1, 4'b0001); chk("left_3", 32'(out), 32'hF);
      chk("left_sout", 32'(sout), 1);
      dir = 1'b0;
      step(1'b1, 4'b0000); chk("right_after_left", 32'(out), 32'h7);
`endif

      // Random phase. Some cycles include a short reset pulse between edges.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
`ifdef SHIFT_REG_LEFT_EN
         dir = 1'($urandom_range(0, 1));
`endif
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
         if ($urandom_range(0, 19) == 0) begin
            #1 rst_n = 1'b0;
            #1;
            chk("rand_async_reset", 32'(out), 32'h0);
            #1 rst_n = 1'b1;
         end
      end

      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule : tb_shift_reg4_pl
